// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter loading one shared WIDTH-bit register,
// with a programmable hold window after every grant.
module shared_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(HOLD_CYCLES + 2)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IW-1:0]          q_owner,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic q_valid_q, q_valid_d, busy_q, busy_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, win_q, win_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  // Descending scan so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    int j;
    j = 0;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      j = j >= N_REQ ? j - N_REQ : j;
      if (req[j]) pick = IW'(j);
    end
  end
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    q_d       = q_q;
    q_valid_d = 1'b0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d   = N_REQ'(1) << pick;
        ptr_d   = pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1;
        win_d   = pick;
        state_d = GRANT;
      end
      GRANT: if (req[win_q]) begin
        q_d       = data[win_q*WIDTH +: WIDTH];
        owner_d   = win_q;
        q_valid_d = 1'b1;
        cnt_d     = CW'(HOLD_CYCLES);
        state_d   = HOLD_CYCLES == 0 ? IDLE : HOLD;
      end else begin
        state_d = IDLE;
      end
      HOLD: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
    // Stays high through the cycle the arbiter spends returning to IDLE
    busy_d = state_d != IDLE || state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end
  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_owner = owner_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: cycle table plus hand sequences for shared_reg_arbiter,
// with a load scoreboard per instance (HOLD_CYCLES=2 and HOLD_CYCLES=0).
module tb_shared_reg_arbiter;
  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       qv;
    logic       busy;
    logic [7:0] q;
    logic [1:0] own;
  } vec_t;
  typedef struct packed {
    logic [7:0] q;
    logic [1:0] own;
  } exp_t;
  logic clk = 1'b0;
  logic rstn_a, rstn_b;
  logic [3:0] req_a, req_b, gnt_a, gnt_b;
  logic [31:0] data_a, data_b;
  logic [7:0] q_a, q_b;
  logic qv_a, qv_b, busy_a, busy_b;
  logic [1:0] own_a, own_b;
  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  exp_t sb_a[$], sb_b[$];
  logic [7:0] dv [4];
  always #5 clk = ~clk;
  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rstn(rstn_a), .req(req_a), .data(data_a), .gnt(gnt_a),
    .q(q_a), .q_valid(qv_a), .q_owner(own_a), .busy(busy_a));
  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rstn(rstn_b), .req(req_b), .data(data_b), .gnt(gnt_b),
    .q(q_b), .q_valid(qv_b), .q_owner(own_b), .busy(busy_b));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                              input logic qv, input logic b, input logic [7:0] qq,
                              input logic [1:0] o);
    tbl.push_back('{r, rq, g, qv, b, qq, o});
  endfunction
  always @(posedge clk) begin
    #3;
    if (qv_a) begin
      if (sb_a.size() == 0) chk("sb_a_unexpected_load", 32'(q_a), 32'hxx);
      else begin
        exp_t e;
        e = sb_a.pop_front();
        chk("sb_a_q", 32'(q_a), 32'(e.q));
        chk("sb_a_owner", 32'(own_a), 32'(e.own));
      end
    end
    if (qv_b) begin
      if (sb_b.size() == 0) chk("sb_b_unexpected_load", 32'(q_b), 32'hxx);
      else begin
        exp_t e;
        e = sb_b.pop_front();
        chk("sb_b_q", 32'(q_b), 32'(e.q));
        chk("sb_b_owner", 32'(own_b), 32'(e.own));
      end
    end
  end
  initial begin
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h44;
    rstn_a = 1'b0; req_a = '0; data_a = 32'h44A52211;
    rstn_b = 1'b0; req_b = '0; data_b = '0;
    for (int i = 0; i < 3; i++) add(0, 4'hF, 0, 0, 0, 8'h00, 0);
    add(1, 4'h4, 0, 0, 0, 8'h00, 0);
    add(1, 4'h4, 4'h4, 0, 1, 8'h00, 0);
    add(1, 4'h4, 0, 1, 1, 8'hA5, 2);
    add(1, 4'h4, 0, 0, 1, 8'hA5, 2);
    add(1, 4'h4, 0, 0, 1, 8'hA5, 2);
    add(1, 4'h4, 4'h4, 0, 1, 8'hA5, 2);
    add(1, 4'h0, 0, 1, 1, 8'hA5, 2);
    add(1, 4'h0, 0, 0, 1, 8'hA5, 2);
    add(1, 4'h0, 0, 0, 1, 8'hA5, 2);
    add(1, 4'h0, 0, 0, 0, 8'hA5, 2);
    add(0, 4'h0, 0, 0, 0, 8'hA5, 2);
    add(1, 4'hF, 0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      add(1, 4'hF, 4'(1) << o, 0, 1, k == 0 ? 8'h00 : dv[(k + 3) % 4], k == 0 ? 2'd0 : 2'((k + 3) % 4));
      add(1, k == 4 ? 4'h0 : 4'hF, 0, 1, 1, dv[o], 2'(o));
      if (k < 4) begin
        add(1, 4'hF, 0, 0, 1, dv[o], 2'(o));
        add(1, 4'hF, 0, 0, 1, dv[o], 2'(o));
      end
    end
    add(1, 4'h0, 0, 0, 1, 8'h11, 0);
    add(1, 4'h0, 0, 0, 1, 8'h11, 0);
    add(1, 4'h0, 0, 0, 0, 8'h11, 0);
    repeat (2) @(posedge clk);
    foreach (tbl[n]) begin
      vec_t v;
      v = tbl[n];
      @(negedge clk);
      chk($sformatf("row%0d_gnt", n), 32'(gnt_a), 32'(v.gnt));
      chk($sformatf("row%0d_qvalid", n), 32'(qv_a), 32'(v.qv));
      chk($sformatf("row%0d_busy", n), 32'(busy_a), 32'(v.busy));
      chk($sformatf("row%0d_q", n), 32'(q_a), 32'(v.q));
      chk($sformatf("row%0d_owner", n), 32'(own_a), 32'(v.own));
      rstn_a = v.rstn;
      req_a = v.req;
      if (v.rstn && (v.req & v.gnt) != 0)
        for (int i = 0; i < 4; i++)
          if (v.gnt[i]) sb_a.push_back('{data_a[i*8 +: 8], 2'(i)});
    end
    @(negedge clk);
    chk("abort_idle_before", 32'(busy_a), 32'd0);
    req_a = 4'b0010;
    @(negedge clk);
    chk("abort_gnt1", 32'(gnt_a), 32'h2);
    req_a = 4'b1101;
    @(negedge clk);
    chk("abort_no_qvalid", 32'(qv_a), 32'd0);
    chk("abort_q_kept", 32'(q_a), 32'h11);
    chk("abort_owner_kept", 32'(own_a), 32'd0);
    chk("abort_gnt_clear", 32'(gnt_a), 32'd0);
    req_a = 4'b1111;
    data_a = 32'h443C2211;
    @(negedge clk);
    chk("abort_next_winner", 32'(gnt_a), 32'h4);
    sb_a.push_back('{8'h3C, 2'd2});
    @(negedge clk);
    chk("hold_loaded_3c", 32'(q_a), 32'h3C);
    chk("hold_loaded_qvalid", 32'(qv_a), 32'd1);
    rstn_a = 1'b0;
    @(negedge clk);
    chk("midhold_rst_q", 32'(q_a), 32'd0);
    chk("midhold_rst_busy", 32'(busy_a), 32'd0);
    chk("midhold_rst_owner", 32'(own_a), 32'd0);
    chk("midhold_rst_gnt", 32'(gnt_a), 32'd0);
    rstn_a = 1'b1;
    req_a = 4'b1010;
    @(negedge clk);
    chk("post_rst_ptr0_gnt", 32'(gnt_a), 32'h2);
    sb_a.push_back('{8'h22, 2'd1});
    @(negedge clk);
    chk("post_rst_q", 32'(q_a), 32'h22);
    chk("post_rst_owner", 32'(own_a), 32'd1);
    req_a = '0;
    @(negedge clk);
    rstn_b = 1'b1;
    req_b = 4'b0001;
    data_b = 32'h0000005A;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("h0_c%0d_qvalid", c), 32'(qv_b), 32'(c % 2 == 0));
      chk($sformatf("h0_c%0d_busy", c), 32'(busy_b), 32'd1);
      chk($sformatf("h0_c%0d_gnt", c), 32'(gnt_b), 32'(c % 2));
      if (c % 2 == 1) sb_b.push_back('{8'h5A, 2'd0});
    end
    req_b = '0;
    repeat (4) @(negedge clk);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
